// File: rtl/output_arbiter_pkg.sv
// rtl/output_arbiter_pkg.sv - shared state encoding, defaults and slice helper for output_arbiter
package output_arbiter_pkg;

  // One-hot state vector: bit positions and width
  localparam int ST_W      = 4;
  localparam int ST_IDLE_B  = 0;
  localparam int ST_GRANT_B = 1;
  localparam int ST_HOLD_B  = 2;
  localparam int ST_DRAIN_B = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 4'(1 << ST_IDLE_B),
    ST_GRANT = 4'(1 << ST_GRANT_B),
    ST_HOLD  = 4'(1 << ST_HOLD_B),
    ST_DRAIN = 4'(1 << ST_DRAIN_B)
  } state_t;

  // Tape character width used when the top is not overridden
  localparam int DATA_W_DEF = 5;

  // Lowest bit of requester idx inside a packed idx-major data bus
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/output_arbiter_rr_pick.sv
// rtl/output_arbiter_rr_pick.sv - combinational winner select; OUTPUT_ARB_FIXED_PRIO_EN selects lowest-index priority
module rr_pick
  import output_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

`ifdef OUTPUT_ARB_FIXED_PRIO_EN
  // The search origin is meaningless here; fold it away without leaving a dangling input
  logic ptr_unused;
  assign ptr_unused = ^ptr;

  // Lowest asserted index wins; scan downwards so the last hit is the smallest
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = IDX_W'(i);
        valid  = 1'b1;
      end
    end
  end
`else
  // Walk the requesters starting at ptr, wrapping at N_REQ, and take the first one asserted
  always_comb begin
    logic [IDX_W-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/output_arbiter.sv
// rtl/output_arbiter.sv - shares the tape output channel among N_REQ four-phase requesters; OUTPUT_ARB_FIXED_PRIO_EN selects fixed priority
module output_arbiter
  import output_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_rdy,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    output_rdy,
  input  logic                    output_ack,
  output logic [DATA_W-1:0]       output_data,
  output logic                    busy
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [DATA_W-1:0]  data_q;
  logic               take_grant;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req_rdy),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign take_grant = (state_q == ST_IDLE) && pick_valid;

  // State register; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winner and its character at grant time; both hold until the next grant
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= '0;
      data_q  <= '0;
    end else if (take_grant) begin
      grant_q <= pick_idx;
      data_q  <= req_data[slice_lsb(int'(pick_idx), DATA_W) +: DATA_W];
    end
  end

`ifdef OUTPUT_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  // Round-robin origin moves to the requester after the one just granted
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (take_grant) begin
      ptr_q <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`endif

  // Next-state and decoded outputs; outputs depend only on registered state and grant
  always_comb begin
    state_d    = state_q;
    output_rdy = 1'b0;
    req_ack    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        output_rdy = 1'b1;
        if (output_ack) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        output_rdy       = 1'b1;
        req_ack[grant_q] = 1'b1;
        if (!req_rdy[grant_q]) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        req_ack[grant_q] = 1'b1;
        if (!output_ack) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign output_data = data_q;

endmodule

// File: tb/tb_output_arbiter.sv
// tb/tb_output_arbiter.sv - scoreboard bench for output_arbiter with requester and tape models
`timescale 1ns/1ps
module tb_output_arbiter;

  localparam int N_REQ  = 2;
  localparam int DATA_W = 5;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req_rdy;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ack;
  logic                    output_rdy;
  logic                    output_ack;
  logic [DATA_W-1:0]       output_data;
  logic                    busy;

  output_arbiter #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_rdy     (req_rdy),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .output_rdy  (output_rdy),
    .output_ack  (output_ack),
    .output_data (output_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int pushed = 0;
  int ack_pulses = 0;
  int chars = 0;
  int hold1_cycles = 0;
  logic [DATA_W-1:0] last_char = '0;
  logic [N_REQ-1:0]  prev_ack  = '0;
  logic prev_rdy  = 1'b0;
  logic prev_busy = 1'b0;

  int ack_delay    = 2;
  int release_hold = 0;
  int tape_cnt     = 0;

  int                pend     [N_REQ];
  int                hold     [N_REQ];
  int                hcnt     [N_REQ];
  logic [DATA_W-1:0] dat      [N_REQ];
  logic [DATA_W-1:0] alt      [N_REQ];
  logic              chg      [N_REQ];
  logic              withdraw [N_REQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input int idx, input logic [DATA_W-1:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic monitor();
    exp_t e;
    if (req_ack != '0 && prev_ack == '0) begin
      ack_pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(req_ack), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("ack_idx", 32'(req_ack), 32'(1) << e.idx);
        chk("ack_data", 32'(output_data), 32'(e.data));
        chk("tape_char", 32'(last_char), 32'(e.data));
      end
    end
    if (output_rdy && !prev_rdy) chk("grant_while_busy", 32'(prev_busy), 32'(0));
    if (req_ack[1] && output_rdy) hold1_cycles++;
    prev_ack  = req_ack;
    prev_rdy  = output_rdy;
    prev_busy = busy;
  endtask

  task automatic tape();
    if (!output_ack) begin
      if (output_rdy) begin
        if (tape_cnt >= ack_delay) begin
          output_ack = 1'b1;
          last_char  = output_data;
          chars++;
          tape_cnt = 0;
        end else tape_cnt++;
      end else tape_cnt = 0;
    end else begin
      if (!output_rdy) begin
        if (tape_cnt >= release_hold) begin
          output_ack = 1'b0;
          tape_cnt   = 0;
        end else tape_cnt++;
      end else tape_cnt = 0;
    end
  endtask

  task automatic agents();
    for (int i = 0; i < N_REQ; i++) begin
      if (!req_rdy[i]) begin
        if (pend[i] > 0 && !req_ack[i]) begin
          req_rdy[i] = 1'b1;
          req_data[i*DATA_W +: DATA_W] = dat[i];
          hcnt[i] = 0;
        end
      end else if (req_ack[i]) begin
        if (hcnt[i] >= hold[i]) begin
          req_rdy[i] = 1'b0;
          pend[i]--;
        end else hcnt[i]++;
      end else if (output_rdy) begin
        if (chg[i]) req_data[i*DATA_W +: DATA_W] = alt[i];
        if (withdraw[i]) begin
          req_rdy[i] = 1'b0;
          pend[i]--;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    tape();
    agents();
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((pend[0] != 0 || pend[1] != 0 || req_rdy != '0 || busy || output_ack) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(n < budget), 32'(1));
  endtask

  initial begin
    int n;
    int p0;
    int c0;
    int h0;
    reset      = 1'b1;
    req_rdy    = '0;
    req_data   = '0;
    output_ack = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      pend[i] = 0; hold[i] = 0; hcnt[i] = 0;
      dat[i] = '0; alt[i] = '0; chg[i] = 1'b0; withdraw[i] = 1'b0;
    end

    // reset state
    repeat (3) step();
    chk("rst_rdy",  32'(output_rdy),  32'(0));
    chk("rst_ack",  32'(req_ack),     32'(0));
    chk("rst_busy", 32'(busy),        32'(0));
    chk("rst_data", 32'(output_data), 32'(0));
    reset = 1'b0;
    step();

    // contention: both requesting continuously for four transfers
    dat[0] = 5'h03;
    dat[1] = 5'h1C;
    for (int k = 0; k < 4; k++) begin
`ifdef OUTPUT_ARB_FIXED_PRIO_EN
      push_exp(0, 5'h03);
`else
      push_exp(k % 2, (k % 2 == 1) ? 5'h1C : 5'h03);
`endif
    end
    p0 = ack_pulses;
    pend[0] = 100;
    pend[1] = 100;
    n = 0;
    while (ack_pulses < p0 + 4 && n < 400) begin
      step();
      n++;
    end
    chk("t2_wait", 32'(n < 400), 32'(1));
    for (int i = 0; i < N_REQ; i++) begin
      if (!req_ack[i]) req_rdy[i] = 1'b0;
      pend[i] = 0;
    end
    run_idle("t2_idle", 200);
    chk("t2_pulses", 32'(ack_pulses - p0), 32'(4));

    // single transfer with cycle-exact handshake timing
    c0 = chars;
    dat[0] = 5'b10110;
    push_exp(0, 5'b10110);
    pend[0] = 1;
    step();
    chk("t1_rdy_before", 32'(output_rdy), 32'(0));
    step();
    chk("t1_rdy_lat",  32'(output_rdy),  32'(1));
    chk("t1_data",     32'(output_data), 32'(5'b10110));
    chk("t1_busy",     32'(busy),        32'(1));
    n = 0;
    while (!output_ack && n < 50) begin
      step();
      n++;
    end
    chk("t1_ack_wait", 32'(n < 50), 32'(1));
    chk("t1_ack_pre",  32'(req_ack), 32'(0));
    step();
    chk("t1_ack_lat",  32'(req_ack), 32'(2'b01));
    step();
    chk("t1_rdy_drop", 32'(output_rdy), 32'(0));
    chk("t1_drain_ack", 32'(req_ack), 32'(2'b01));
    step();
    chk("t1_idle_busy", 32'(busy),    32'(0));
    chk("t1_idle_ack",  32'(req_ack), 32'(0));
    run_idle("t1_idle", 100);
    chk("t1_chars", 32'(chars - c0), 32'(1));

    // data stability: requester changes its data while in GRANT
    dat[0] = 5'h0A;
    alt[0] = 5'h1F;
    chg[0] = 1'b1;
    push_exp(0, 5'h0A);
    pend[0] = 1;
    run_idle("t3_idle", 100);
    chk("t3_char", 32'(last_char), 32'(5'h0A));
    chg[0] = 1'b0;

    // slow release on both sides, two requesters
    hold[0] = 5;
    hold[1] = 5;
    release_hold = 3;
    dat[0] = 5'h0E;
    dat[1] = 5'h11;
`ifdef OUTPUT_ARB_FIXED_PRIO_EN
    push_exp(0, 5'h0E);
    push_exp(0, 5'h0E);
    push_exp(1, 5'h11);
`else
    push_exp(1, 5'h11);
    push_exp(0, 5'h0E);
    push_exp(0, 5'h0E);
`endif
    p0 = ack_pulses;
    pend[0] = 2;
    pend[1] = 1;
    run_idle("t4_idle", 600);
    chk("t4_pulses", 32'(ack_pulses - p0), 32'(3));
    hold[0] = 0;
    hold[1] = 0;
    release_hold = 0;

    // reset while in HOLD
    dat[0] = 5'h11;
    hold[0] = 20;
    push_exp(0, 5'h11);
    pend[0] = 1;
    n = 0;
    while (!req_ack[0] && n < 50) begin
      step();
      n++;
    end
    chk("t5_hold_wait", 32'(n < 50), 32'(1));
    step();
    step();
    reset   = 1'b1;
    req_rdy = '0;
    pend[0] = 0;
    hold[0] = 0;
    step();
    chk("t5_rst_rdy",  32'(output_rdy),  32'(0));
    chk("t5_rst_ack",  32'(req_ack),     32'(0));
    chk("t5_rst_busy", 32'(busy),        32'(0));
    chk("t5_rst_data", 32'(output_data), 32'(0));
    reset = 1'b0;
    run_idle("t5_rst_idle", 100);
    dat[0] = 5'h07;
    dat[1] = 5'h19;
    push_exp(0, 5'h07);
    push_exp(1, 5'h19);
    pend[0] = 1;
    pend[1] = 1;
    run_idle("t5_ptr_idle", 200);
    push_exp(1, 5'h19);
    pend[1] = 1;
    run_idle("t5_req1_idle", 100);

    // early withdrawal by requester 1 during GRANT
    dat[1] = 5'h15;
    withdraw[1] = 1'b1;
    push_exp(1, 5'h15);
    h0 = hold1_cycles;
    pend[1] = 1;
    run_idle("t6_idle", 100);
    chk("t6_hold_cycles", 32'(hold1_cycles - h0), 32'(1));
    withdraw[1] = 1'b0;

    repeat (3) step();
    chk("exp_left",    32'(exp_q.size()), 32'(0));
    chk("pulse_total", 32'(ack_pulses),   32'(pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
